// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stall vectors,
// FSM state encoding and the stall priority merge.
package pipeline_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_MDU   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  // Deepest requesting stage wins: it freezes everything upstream of itself.
  function automatic logic [5:0] stall_prio(input logic r_if, input logic r_id,
                                            input logic r_ex, input logic r_mem);
    if (r_mem)     return STALL_MEM;
    else if (r_ex) return STALL_EX;
    else if (r_id) return STALL_ID;
    else if (r_if) return STALL_IF;
    else           return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module pipeline_ctrl_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && (~cnt_q != '0)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: merges stage stall requests, sequences the
// MDU start/cancel handshake, issues exception flush/redirect, tracks stalls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WDOG_MAX = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             ex_mdu_req,
  input  logic             mdu_done,
  input  logic             excp_valid,
  input  logic [31:0]      excp_target,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             mdu_start,
  output logic             mdu_cancel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             timeout
);

  localparam int WD_W = $clog2(WDOG_MAX + 1);

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic        timeout_q, timeout_d;
  logic [5:0]  stall_c;
  logic        flush_c, start_c, cancel_c;
  logic [31:0] new_pc_c;
  logic [WD_W-1:0] run_cnt;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    stall_c  = STALL_NONE;
    flush_c  = 1'b0;
    start_c  = 1'b0;
    cancel_c = 1'b0;
    new_pc_c = '0;
    case (state_q)
      S_RUN: begin
        if (excp_valid) begin
          flush_c  = 1'b1;
          new_pc_c = excp_target;
          state_d  = S_FLUSH;
        end else if (ex_mdu_req) begin
          start_c = 1'b1;
          stall_c = stallreq_mem ? STALL_MEM : STALL_EX;
          pend_d  = 1'b0;
          state_d = S_MDU;
        end else begin
          stall_c = stall_prio(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        end
      end
      S_MDU: begin
        // A done pulse landing under a MEM stall is remembered so EX can
        // release once MEM frees up.
        if (excp_valid) begin
          cancel_c = 1'b1;
          flush_c  = 1'b1;
          new_pc_c = excp_target;
          pend_d   = 1'b0;
          state_d  = S_FLUSH;
        end else if ((mdu_done || pend_q) && !stallreq_mem) begin
          stall_c = stall_prio(stallreq_if, stallreq_id, stallreq_ex, 1'b0);
          pend_d  = 1'b0;
          state_d = S_RUN;
        end else begin
          stall_c = stallreq_mem ? STALL_MEM : STALL_EX;
          pend_d  = pend_q | mdu_done;
        end
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  assign timeout_d = timeout_q | ((stall_c != STALL_NONE) && (run_cnt == WD_W'(WDOG_MAX - 1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RUN;
      pend_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      timeout_q <= timeout_d;
    end
  end

  pipeline_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (reset),
    .clr (1'b0),
    .inc (stall_c != STALL_NONE),
    .cnt (stall_cycles)
  );

  pipeline_ctrl_sat_counter #(.W(WD_W)) u_wdog_cnt (
    .clk (clk),
    .rst (reset),
    .clr ((stall_c == STALL_NONE) || flush_c),
    .inc (1'b1),
    .cnt (run_cnt)
  );

  assign stall      = reset ? STALL_NONE : stall_c;
  assign flush      = reset ? 1'b0 : flush_c;
  assign new_pc     = reset ? 32'h0 : new_pc_c;
  assign mdu_start  = reset ? 1'b0 : start_c;
  assign mdu_cancel = reset ? 1'b0 : cancel_c;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: per-cycle expected outputs queued at
// drive time and compared mid-cycle; counters checked inline per scenario.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
  localparam int WDOG  = 16;
  localparam logic [5:0] S0 = 6'b000000, SIF = 6'b000011, SID = 6'b000111,
                         SEX = 6'b001111, SMEM = 6'b011111;
  localparam logic [3:0] R_IF = 4'b0001, R_ID = 4'b0010, R_EX = 4'b0100, R_MEM = 4'b1000;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0, reset = 1'b0;
  logic stallreq_if = 0, stallreq_id = 0, stallreq_ex = 0, stallreq_mem = 0;
  logic ex_mdu_req = 0, mdu_done = 0, excp_valid = 0;
  logic [31:0] excp_target = '0;
  logic [5:0] stall;
  logic flush, mdu_start, mdu_cancel, timeout;
  logic [31:0] new_pc;
  logic [CNT_W-1:0] stall_cycles;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        start;
    logic        cancel;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  pipeline_ctrl #(.CNT_W(CNT_W), .WDOG_MAX(WDOG)) dut (
    .clk(clk), .reset(reset),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .ex_mdu_req(ex_mdu_req), .mdu_done(mdu_done),
    .excp_valid(excp_valid), .excp_target(excp_target),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .mdu_start(mdu_start), .mdu_cancel(mdu_cancel),
    .stall_cycles(stall_cycles), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_chk++;
      if ({stall, flush, new_pc, mdu_start, mdu_cancel} !==
          {e.stall, e.flush, e.pc, e.start, e.cancel}) begin
        n_fail++;
        $display("FAIL %s: got stall=%b flush=%b pc=%h start=%b cancel=%b, want stall=%b flush=%b pc=%h start=%b cancel=%b",
                 e.name, stall, flush, new_pc, mdu_start, mdu_cancel,
                 e.stall, e.flush, e.pc, e.start, e.cancel);
      end
    end
  end

  // One cycle: rq = {mem,ex,id,if}; drive just after the edge, queue expectation.
  task automatic cyc(input logic rs, input logic [3:0] rq, input logic mreq,
                     input logic done, input logic ex, input logic [31:0] tgt,
                     input logic [5:0] es, input logic ef, input logic [31:0] ep,
                     input logic est, input logic ecn, input string nm);
    exp_t x;
    @(posedge clk); #1;
    reset = rs;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = rq;
    ex_mdu_req = mreq; mdu_done = done; excp_valid = ex; excp_target = tgt;
    x.stall = es; x.flush = ef; x.pc = ep; x.start = est; x.cancel = ecn; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic chk_cnt(input logic [CNT_W-1:0] exp_c, input logic exp_t_o, input string nm);
    n_chk++;
    if (stall_cycles !== exp_c || timeout !== exp_t_o) begin
      n_fail++;
      $display("FAIL %s: got stall_cycles=%0d timeout=%b, want stall_cycles=%0d timeout=%b",
               nm, stall_cycles, timeout, exp_c, exp_t_o);
    end
  endtask

  task automatic do_reset();
    cyc(1, 4'b0000, 0, 0, 0, 0, S0, 0, 0, 0, 0, "rst");
    cyc(0, 4'b0000, 0, 0, 0, 0, S0, 0, 0, 0, 0, "rst_rel");
  endtask

  task automatic test_reset();
    cyc(1, 4'b1111, 1, 1, 1, VEC, S0, 0, 0, 0, 0, "reset_forces_zero");
    cyc(1, 4'b1111, 1, 0, 0, VEC, S0, 0, 0, 0, 0, "reset_forces_zero2");
    chk_cnt(0, 0, "reset_counters");
    cyc(0, 4'b0000, 0, 0, 0, 0, S0, 0, 0, 0, 0, "reset_release");
  endtask

  task automatic test_id_stall();
    do_reset();
    cyc(0, R_ID, 0, 0, 0, 0, SID, 0, 0, 0, 0, "id_stall");
    cyc(0, 4'b0000, 0, 0, 0, 0, S0, 0, 0, 0, 0, "id_release");
    chk_cnt(1, 0, "id_stall_count");
  endtask

  task automatic test_priority();
    do_reset();
    cyc(0, R_IF | R_MEM, 0, 0, 0, 0, SMEM, 0, 0, 0, 0, "prio_if_mem");
    cyc(0, R_IF, 0, 0, 0, 0, SIF, 0, 0, 0, 0, "prio_if_only");
    cyc(0, R_EX, 0, 0, 0, 0, SEX, 0, 0, 0, 0, "prio_ex_only");
    cyc(0, R_ID | R_IF, 0, 0, 0, 0, SID, 0, 0, 0, 0, "prio_id_if");
    cyc(0, R_EX | R_ID | R_IF, 0, 0, 0, 0, SEX, 0, 0, 0, 0, "prio_ex_id_if");
    cyc(0, 4'b0000, 0, 0, 0, 0, S0, 0, 0, 0, 0, "prio_none");
    chk_cnt(5, 0, "prio_count");
  endtask

  task automatic test_mdu();
    do_reset();
    cyc(0, 4'b0000, 1, 0, 0, 0, SEX, 0, 0, 1, 0, "mdu_start");
    for (int i = 0; i < 8; i++)
      cyc(0, 4'b0000, 1, 0, 0, 0, SEX, 0, 0, 0, 0, "mdu_wait");
    cyc(0, 4'b0000, 1, 1, 0, 0, S0, 0, 0, 0, 0, "mdu_done");
    chk_cnt(9, 0, "mdu_count");
    cyc(0, R_ID, 0, 0, 0, 0, SID, 0, 0, 0, 0, "mdu_back_in_run");
  endtask

  task automatic test_mdu_cancel();
    do_reset();
    cyc(0, 4'b0000, 1, 0, 0, 0, SEX, 0, 0, 1, 0, "cancel_start");
    cyc(0, 4'b0000, 1, 0, 0, 0, SEX, 0, 0, 0, 0, "cancel_wait");
    cyc(0, 4'b0000, 1, 1, 1, VEC, S0, 1, VEC, 0, 1, "cancel_beats_done");
    cyc(0, 4'b1111, 1, 1, 1, 32'h1234, S0, 0, 0, 0, 0, "flush_ignores_reqs");
    cyc(0, R_ID, 0, 0, 0, 0, SID, 0, 0, 0, 0, "after_flush_run");
    cyc(0, 4'b0000, 0, 0, 1, 32'h80000180, S0, 1, 32'h80000180, 0, 0, "run_excp_flush");
    cyc(0, 4'b0000, 0, 0, 0, 0, S0, 0, 0, 0, 0, "run_excp_flush_cycle");
  endtask

  task automatic test_mdu_mem();
    do_reset();
    cyc(0, R_MEM, 1, 0, 0, 0, SMEM, 0, 0, 1, 0, "mdumem_start");
    cyc(0, R_MEM, 1, 1, 0, 0, SMEM, 0, 0, 0, 0, "mdumem_done_held");
    cyc(0, R_MEM, 1, 0, 0, 0, SMEM, 0, 0, 0, 0, "mdumem_still_mem");
    cyc(0, 4'b0000, 1, 0, 0, 0, S0, 0, 0, 0, 0, "mdumem_exit");
    cyc(0, 4'b0000, 1, 0, 0, 0, SEX, 0, 0, 1, 0, "mdumem_restart");
    cyc(0, 4'b0000, 1, 1, 0, 0, S0, 0, 0, 0, 0, "mdumem_done2");
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 10; i++) cyc(0, R_MEM, 0, 0, 0, 0, SMEM, 0, 0, 0, 0, "wd_run_a");
    cyc(0, 4'b0000, 0, 0, 0, 0, S0, 0, 0, 0, 0, "wd_gap");
    for (int i = 0; i < 15; i++) cyc(0, R_MEM, 0, 0, 0, 0, SMEM, 0, 0, 0, 0, "wd_run_b");
    cyc(0, 4'b0000, 0, 0, 0, 0, S0, 0, 0, 0, 0, "wd_gap2");
    chk_cnt(4'hF, 0, "wd_cleared_by_gap");
    for (int i = 0; i < 15; i++) cyc(0, R_MEM, 0, 0, 0, 0, SMEM, 0, 0, 0, 0, "wd_run_c");
    cyc(0, R_MEM, 0, 0, 0, 0, SMEM, 0, 0, 0, 0, "wd_run_16th");
    chk_cnt(4'hF, 0, "wd_not_yet");
    cyc(0, 4'b0000, 0, 0, 0, 0, S0, 0, 0, 0, 0, "wd_release");
    chk_cnt(4'hF, 1, "wd_timeout_set");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 0, 0, 0, 0, S0, 0, 0, 0, 0, "wd_idle");
    chk_cnt(4'hF, 1, "wd_timeout_sticky");
  endtask

  task automatic test_reset_mid_mdu();
    do_reset();
    cyc(0, 4'b0000, 1, 0, 0, 0, SEX, 0, 0, 1, 0, "rmdu_start");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 1, 0, 0, 0, SEX, 0, 0, 0, 0, "rmdu_wait");
    cyc(1, 4'b0000, 1, 0, 1, VEC, S0, 0, 0, 0, 0, "rmdu_reset_no_cancel");
    #1;
    chk_cnt(0, 0, "rmdu_counters_cleared");
    cyc(0, R_ID, 0, 0, 0, 0, SID, 0, 0, 0, 0, "rmdu_in_run");
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, R_EX, 0, 0, 0, 0, SEX, 0, 0, 0, 0, "sat_stall");
    cyc(0, 4'b0000, 0, 0, 0, 0, S0, 0, 0, 0, 0, "sat_release");
    chk_cnt(4'hF, 1, "sat_hold");
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_priority();
    test_mdu();
    test_mdu_cancel();
    test_mdu_mem();
    test_watchdog();
    test_reset_mid_mdu();
    test_saturate();
    @(posedge clk); @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
